ysyx_23060111_core_seq: RTL and testbench
=========================================

# ysyx_23060111_core_seq

Multi-cycle instruction sequencer for the ysyx_23060111 RV32E core, replacing the single-cycle pc/IFU/EXU/mem hookup at the top level. It owns the PC and a fetch→execute→memory→writeback state machine with valid/ready handshakes to instruction and data memory. It gates register-file writes and PC updates, and raises a sticky halt on ebreak, an invalid opcode, or a bus timeout. The top level instantiates it between the IFU/mem ports and the existing IDU/EXU datapath.

## Interface
Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h8000_0000, PC value after reset
- TIMEOUT, 255, max cycles spent in any one wait state before bus error; valid range 1..65535

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- pc  out  XLEN  PC of the instruction in flight
- inst  out  32  latched instruction, feeds IDU
- if_req_valid  out  1  fetch request; address is pc
- if_req_ready  in  1  imem accepts request
- if_rsp_valid  in  1  fetch data valid
- if_rsp_data  in  32  fetched word
- exu_dnpc  in  XLEN  next PC computed by EXU from inst
- exu_rf_wen  in  1  instruction writes rd
- exu_is_load / exu_is_store  in  1 each  memory instruction
- exu_mem_addr  in  XLEN  load/store address
- exu_mem_wdata  in  XLEN  store data
- exu_mem_wmask  in  4  store byte mask
- exu_ebreak / exu_inv  in  1 each  ebreak decoded / invalid opcode
- dm_req_valid  out  1  data request
- dm_req_we  out  1  1 = store
- dm_req_addr  out  XLEN; dm_req_wdata  out  XLEN; dm_req_wmask  out  4
- dm_req_ready  in  1  dmem accepts request
- dm_rsp_valid  in  1  load data valid, or store done
- dm_rsp_rdata  in  XLEN  load data
- ld_data  out  XLEN  latched load data for writeback mux
- rf_wen  out  1  register-file write strobe
- commit  out  1  instruction retired
- retire_cnt  out  32  retired instruction count
- halt  out  1  sticky stop
- halt_code  out  2  01 ebreak, 10 invalid, 11 bus timeout

## Operation
- States:
  - FETCH: if_req_valid=1. On if_req_ready, go to IWAIT.
  - IWAIT: on if_rsp_valid, latch inst and go to EXEC.
  - EXEC (one cycle), priority in this order:
    - exu_ebreak → HALT, code 01
    - exu_inv → HALT, code 10
    - load or store → MREQ
    - otherwise → WB
  - MREQ: dm_req_valid=1, with dm_req_we/addr/wdata/wmask driven from the exu_* inputs; wmask is forced to 0 on loads. On dm_req_ready, go to MWAIT.
  - MWAIT: on dm_rsp_valid, latch ld_data (loads only) and go to WB.
  - WB (one cycle):
    - rf_wen = exu_rf_wen & ~exu_is_store
    - pc ← exu_dnpc
    - commit=1, retire_cnt += 1 (wraps modulo 2^32)
    - → FETCH
  - HALT: absorbing; no requests issued, no rf_wen; only rst exits.
- Wait timer:
  - Cleared on every state entry; increments each cycle spent in FETCH, IWAIT, MREQ or MWAIT.
  - Reaching TIMEOUT without the awaited handshake → HALT, code 11.
- Response rules:
  - Responses are accepted only in IWAIT/MWAIT; if_rsp_valid/dm_rsp_valid in any other state are ignored.
  - Request outputs stay stable while valid is high and ready is low.
- Entering HALT on ebreak or invalid does not commit; pc keeps the faulting instruction's address.
- The exu_* inputs are sampled only in EXEC/MREQ/WB, and are stable there because inst is held.

## Timing
- Reset values: state FETCH, pc=RESET_PC, inst=0, ld_data=0, retire_cnt=0, halt=0, halt_code=00. rf_wen, commit, if_req_valid and dm_req_valid are 0 during reset, and if_req_valid=1 in the first cycle after rst falls.
- rst asserted in any state, including mid-handshake, returns everything to reset values at the next edge. The outstanding response is dropped; memories must tolerate this.
- Latency with zero-wait memory (ready=1 on first request cycle, rsp one cycle later):
  - ALU/branch: 4 cycles per instruction (FETCH, IWAIT, EXEC, WB)
  - load/store: 6 cycles
- Wait states add one cycle each.
- rf_wen and commit are single-cycle pulses, coincident with the pc update edge.
- halt asserts in the cycle after the EXEC that decoded the fault, or the cycle after the timer hits TIMEOUT.

## Test plan
- Reset then ALU stream: 3 non-memory instructions, zero-wait imem, exu_dnpc=pc+4 → commit every 4th cycle; pc goes 0x8000_0000 → 0x8000_0004 → 0x8000_0008 → 0x8000_000C; retire_cnt=3.
- Load with 2 wait cycles on dm_req_ready and 3 on dm_rsp_valid, rdata=0xDEAD_BEEF → ld_data=0xDEAD_BEEF; rf_wen pulses once; instruction takes 6+5=11 cycles.
- Store with wmask=4'b0011 → dm_req_we=1 and wmask=0011 while valid; rf_wen=0 in WB even with exu_rf_wen=1; commit=1.
- ebreak at second instruction → halt=1, halt_code=01, pc=0x8000_0004, retire_cnt=1. No if_req_valid afterwards, even when if_rsp_valid is asserted spuriously.
- TIMEOUT=8, imem never raises if_rsp_valid → halt_code=11 exactly 8 cycles after entering IWAIT; reset mid-IWAIT in a second run restores pc=RESET_PC and state FETCH.
- Back-to-back exu_ebreak and exu_inv both high → halt_code=01 (priority).

Source files
------------

// File: rtl/ysyx_23060111_core_seq_if.sv
// ysyx_23060111_core_seq_if: fetch, data-memory, EXU and retire signals around the sequencer
interface ysyx_23060111_core_seq_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc;
  logic [31:0] inst;
  logic if_req_valid;
  logic if_req_ready;
  logic if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic [XLEN-1:0] exu_dnpc;
  logic exu_rf_wen;
  logic exu_is_load;
  logic exu_is_store;
  logic [XLEN-1:0] exu_mem_addr;
  logic [XLEN-1:0] exu_mem_wdata;
  logic [3:0] exu_mem_wmask;
  logic exu_ebreak;
  logic exu_inv;
  logic dm_req_valid;
  logic dm_req_we;
  logic [XLEN-1:0] dm_req_addr;
  logic [XLEN-1:0] dm_req_wdata;
  logic [3:0] dm_req_wmask;
  logic dm_req_ready;
  logic dm_rsp_valid;
  logic [XLEN-1:0] dm_rsp_rdata;
  logic [XLEN-1:0] ld_data;
  logic rf_wen;
  logic commit;
  logic [31:0] retire_cnt;
  logic halt;
  logic [1:0] halt_code;
  modport master (
    output pc, inst, if_req_valid, dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_wmask,
           ld_data, rf_wen, commit, retire_cnt, halt, halt_code,
    input if_req_ready, if_rsp_valid, if_rsp_data, exu_dnpc, exu_rf_wen, exu_is_load, exu_is_store,
          exu_mem_addr, exu_mem_wdata, exu_mem_wmask, exu_ebreak, exu_inv, dm_req_ready, dm_rsp_valid,
          dm_rsp_rdata
  );
  modport slave (
    input pc, inst, if_req_valid, dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_wmask,
          ld_data, rf_wen, commit, retire_cnt, halt, halt_code,
    output if_req_ready, if_rsp_valid, if_rsp_data, exu_dnpc, exu_rf_wen, exu_is_load, exu_is_store,
           exu_mem_addr, exu_mem_wdata, exu_mem_wmask, exu_ebreak, exu_inv, dm_req_ready, dm_rsp_valid,
           dm_rsp_rdata
  );
endinterface

// File: rtl/ysyx_23060111_core_seq.sv
// ysyx_23060111_core_seq: multi-cycle fetch/exec/mem/writeback sequencer with sticky halt
module ysyx_23060111_core_seq #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ysyx_23060111_core_seq_if.master bus
);
  typedef enum logic [2:0] {FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT} state_t;
  state_t state;
  logic [15:0] tmr;
  logic waiting, hs, tmo;
  always_comb begin
    waiting = state inside {FETCH, IWAIT, MREQ, MWAIT};
    hs = state == FETCH ? bus.if_req_ready :
         state == IWAIT ? bus.if_rsp_valid :
         state == MREQ  ? bus.dm_req_ready :
         state == MWAIT ? bus.dm_rsp_valid : 1'b0;
    tmo = tmr == 16'(TIMEOUT - 1);
  end
  assign bus.if_req_valid = ~rst & (state == FETCH);
  assign bus.dm_req_valid = ~rst & (state == MREQ);
  assign bus.dm_req_we = bus.exu_is_store;
  assign bus.dm_req_addr = bus.exu_mem_addr;
  assign bus.dm_req_wdata = bus.exu_mem_wdata;
  assign bus.dm_req_wmask = bus.exu_is_load ? 4'b0 : bus.exu_mem_wmask;
  assign bus.commit = ~rst & (state == WB);
  assign bus.rf_wen = bus.commit & bus.exu_rf_wen & ~bus.exu_is_store;
  assign bus.halt = state == HALT;
  // tmr restarts on every transition; only a stalled wait state lets it count
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      bus.pc <= RESET_PC;
      bus.inst <= '0;
      bus.ld_data <= '0;
      bus.retire_cnt <= '0;
      bus.halt_code <= '0;
      tmr <= '0;
    end else begin
      tmr <= '0;
      if (waiting && !hs) begin
        if (tmo) begin
          state <= HALT;
          bus.halt_code <= 2'b11;
        end else tmr <= tmr + 16'd1;
      end else
        case (state)
          FETCH: state <= IWAIT;
          IWAIT: begin
            bus.inst <= bus.if_rsp_data;
            state <= EXEC;
          end
          EXEC:
            if (bus.exu_ebreak) begin
              state <= HALT;
              bus.halt_code <= 2'b01;
            end else if (bus.exu_inv) begin
              state <= HALT;
              bus.halt_code <= 2'b10;
            end else state <= (bus.exu_is_load | bus.exu_is_store) ? MREQ : WB;
          MREQ: state <= MWAIT;
          MWAIT: begin
            if (bus.exu_is_load) bus.ld_data <= bus.dm_rsp_rdata;
            state <= WB;
          end
          WB: begin
            bus.pc <= bus.exu_dnpc;
            bus.retire_cnt <= bus.retire_cnt + 32'd1;
            state <= FETCH;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060111_core_seq.sv
// tb_ysyx_23060111_core_seq: random-wait memories and a toy EXU checked against a per-instruction model
module tb_ysyx_23060111_core_seq;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  ysyx_23060111_core_seq_if bus();
  ysyx_23060111_core_seq #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, fails = 0;
  logic rnd = 0, hold = 0, dead = 0, spur = 0, mon_en = 0;
  int iw_req = 0, iw_rsp = 0, dw_req = 0, dw_rsp = 0;
  logic [31:0] rd_fix = 0;
  logic i_rdy = 0, i_vld = 0, d_rdy = 0, d_vld = 0;
  logic [31:0] i_data = 0, d_data = 0;
  logic [31:0] prog[$];
  typedef struct {logic [31:0] i; int lat;} fe_t;
  typedef struct {int lat; logic [31:0] rd;} me_t;
  fe_t fq[$];
  me_t dq[$];
  function automatic logic ld(input logic [31:0] i); return i[1:0] == 2'd1 && !i[6]; endfunction
  function automatic logic st(input logic [31:0] i); return i[1:0] == 2'd2 && !i[6]; endfunction
  function automatic logic ebk(input logic [31:0] i); return i[6:0] == 7'h73 && i[20]; endfunction
  function automatic logic inv(input logic [31:0] i);
    return i[6:0] == 7'h7F || (i[6:0] == 7'h73 && i[21]);
  endfunction
  function automatic logic [31:0] dnpc(input logic [31:0] p, input logic [31:0] i);
    return i[3] ? p + 32'd4 : p + {22'b0, i[31:24], 2'b0};
  endfunction
  assign bus.if_req_ready = i_rdy;
  assign bus.if_rsp_valid = i_vld | spur;
  assign bus.if_rsp_data = i_data;
  assign bus.dm_req_ready = d_rdy;
  assign bus.dm_rsp_valid = d_vld;
  assign bus.dm_rsp_rdata = d_data;
  assign bus.exu_dnpc = dnpc(bus.pc, bus.inst);
  assign bus.exu_rf_wen = bus.inst[2];
  assign bus.exu_is_load = ld(bus.inst);
  assign bus.exu_is_store = st(bus.inst);
  assign bus.exu_mem_addr = {bus.inst[31:4], 4'h0};
  assign bus.exu_mem_wdata = ~bus.inst;
  assign bus.exu_mem_wmask = bus.inst[15:12];
  assign bus.exu_ebreak = ebk(bus.inst);
  assign bus.exu_inv = inv(bus.inst);
  task automatic tick; @(posedge clk); #1; endtask
  task automatic rtick; @(posedge clk); #2; endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic reset_dut;
    mon_en = 0; hold = 1;
    repeat (10) tick;
    rst = 1;
    repeat (2) tick;
    hold = 0; rst = 0; mon_en = 1;
  endtask
  initial begin
    int a, b;
    logic [31:0] w;
    forever begin
      rtick;
      i_rdy = 0; i_vld = 0;
      if (bus.if_req_valid && !hold) begin
        a = rnd ? int'($urandom_range(0, 2)) : iw_req;
        b = rnd ? int'($urandom_range(0, 2)) : iw_rsp;
        repeat (a) rtick;
        i_rdy = 1;
        rtick;
        i_rdy = 0;
        repeat (b) rtick;
        if (!dead) begin
          w = prog.size() != 0 ? prog.pop_front() : ($urandom & ~32'h40);
          fq.push_back('{w, a + b});
          i_data = w; i_vld = 1;
        end
      end
    end
  end
  initial begin
    int a, b;
    logic [31:0] r;
    forever begin
      rtick;
      d_rdy = 0; d_vld = 0;
      if (bus.dm_req_valid && !hold) begin
        a = rnd ? int'($urandom_range(0, 2)) : dw_req;
        b = rnd ? int'($urandom_range(0, 2)) : dw_rsp;
        r = rnd ? $urandom : rd_fix;
        repeat (a) rtick;
        d_rdy = 1;
        rtick;
        d_rdy = 0;
        repeat (b) rtick;
        dq.push_back('{a + b, r});
        d_data = r; d_vld = 1;
      end
    end
  end
  initial begin
    int cyc, e;
    logic jr;
    logic [31:0] m_pc, m_cnt;
    logic m_halt;
    logic [1:0] m_code;
    fe_t f;
    me_t m;
    jr = 0; cyc = 0; m_pc = RPC; m_cnt = 0; m_halt = 0; m_code = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_quiet", 32'({bus.rf_wen, bus.commit, bus.if_req_valid, bus.dm_req_valid}), 0);
        fq.delete(); dq.delete();
        m_pc = RPC; m_cnt = 0; m_halt = 0; m_code = 0; cyc = 0; jr = 1;
      end else begin
        if (mon_en) begin
          if (jr) begin
            chk("rst_pc", bus.pc, RPC);
            chk("rst_inst", bus.inst, 0);
            chk("rst_ld_data", bus.ld_data, 0);
            chk("rst_fetch", 32'(bus.if_req_valid), 1);
          end
          cyc++;
          chk("pc", bus.pc, m_pc);
          chk("retire_cnt", bus.retire_cnt, m_cnt);
          chk("halt", 32'({bus.halt, bus.halt_code}), 32'({m_halt, m_code}));
          if (m_halt) chk("halt_quiet", 32'({bus.if_req_valid, bus.dm_req_valid, bus.commit, bus.rf_wen}), 0);
          if (bus.dm_req_valid && fq.size() != 0) begin
            f = fq[0];
            chk("dm_we", 32'(bus.dm_req_we), 32'(st(f.i)));
            chk("dm_addr", bus.dm_req_addr, {f.i[31:4], 4'h0});
            chk("dm_wmask", 32'(bus.dm_req_wmask), ld(f.i) ? 32'd0 : 32'(f.i[15:12]));
            if (st(f.i)) chk("dm_wdata", bus.dm_req_wdata, ~f.i);
          end
          if (bus.commit) begin
            if (fq.size() == 0) begin
              checks++; fails++;
              $display("FAIL commit with no fetched instruction");
            end else begin
              f = fq.pop_front();
              e = 4 + f.lat;
              if (ld(f.i) || st(f.i)) begin
                if (dq.size() == 0) begin
                  checks++; fails++;
                  $display("FAIL mem commit with no data response");
                end else begin
                  m = dq.pop_front();
                  e += 2 + m.lat;
                  if (ld(f.i)) chk("ld_data", bus.ld_data, m.rd);
                end
              end
              chk("rf_wen", 32'(bus.rf_wen), 32'(f.i[2] && !st(f.i)));
              chk("latency", cyc, e);
              m_pc = dnpc(m_pc, f.i);
              m_cnt++;
              cyc = 0;
            end
          end else chk("rf_wen_idle", 32'(bus.rf_wen), 0);
          if (!m_halt && fq.size() != 0 && cyc == 3 + fq[0].lat && (ebk(fq[0].i) || inv(fq[0].i))) begin
            m_halt = 1;
            m_code = ebk(fq[0].i) ? 2'b01 : 2'b10;
          end
        end
        jr = 0;
      end
    end
  end
  initial begin
    int nw, cw;
    prog = '{32'h8, 32'hC, 32'hB};
    reset_dut();
    repeat (12) tick;
    chk("alu_pc", bus.pc, 32'h8000_000C);
    chk("alu_retire", bus.retire_cnt, 3);
    prog = '{32'hD};
    dw_req = 2; dw_rsp = 3; rd_fix = 32'hDEAD_BEEF;
    reset_dut();
    nw = 0; cw = 0;
    for (int k = 1; k <= 11; k++) begin
      nw += int'(bus.rf_wen);
      if (bus.commit) cw = k;
      tick;
    end
    chk("load_data", bus.ld_data, 32'hDEAD_BEEF);
    chk("load_rf_wen_pulses", nw, 1);
    chk("load_commit_cycle", cw, 11);
    prog = '{32'h300E};
    dw_req = 0; dw_rsp = 0;
    reset_dut();
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) chk("store_req", 32'({bus.dm_req_valid, bus.dm_req_we, bus.dm_req_wmask}), 32'h3F >> 0 & 32'h33);
      if (k == 6) chk("store_wb", 32'({bus.commit, bus.rf_wen}), 32'b10);
      tick;
    end
    prog = '{32'h8, 32'h0010_0073};
    reset_dut();
    repeat (7) tick;
    chk("ebreak_halt", 32'({bus.halt, bus.halt_code}), 32'b101);
    chk("ebreak_pc", bus.pc, 32'h8000_0004);
    chk("ebreak_retire", bus.retire_cnt, 1);
    spur = 1;
    repeat (4) begin
      tick;
      chk("halt_no_fetch", 32'(bus.if_req_valid), 0);
    end
    spur = 0;
    prog = '{32'h0030_0073};
    reset_dut();
    repeat (3) tick;
    chk("priority_halt", 32'({bus.halt, bus.halt_code}), 32'b101);
    prog = '{32'h7F};
    reset_dut();
    repeat (3) tick;
    chk("inv_halt", 32'({bus.halt, bus.halt_code}), 32'b110);
    chk("inv_pc", bus.pc, RPC);
    dead = 1;
    reset_dut();
    mon_en = 0;
    repeat (8) tick;
    chk("timeout_not_yet", 32'(bus.halt), 0);
    tick;
    chk("timeout_halt", 32'({bus.halt, bus.halt_code}), 32'b111);
    reset_dut();
    mon_en = 0;
    repeat (4) tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("midwait_rst_pc", bus.pc, RPC);
    chk("midwait_rst_fetch", 32'({bus.if_req_valid, bus.halt}), 32'b10);
    dead = 0;
    rnd = 1;
    prog.delete();
    reset_dut();
    repeat (3000) tick;
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
